palette_ram_ctrl: RTL and testbench
===================================

Name: palette_ram_ctrl

Overview:
Palette controller for the NES PPU path.
- After reset, or on request, it sequences a 32-entry combinational palette ROM and copies the ROM image into an internal writable palette store.
- It then shares that store between the render pipeline (read port) and a host/CPU write port, applying the NES $3F10/$3F14/$3F18/$3F1C mirroring.
- It sits between the palette ROM and the pixel colour-lookup stage.

Parameters:
- AUTO_INIT, 1, when 1 the block enters LOAD automatically on leaving reset; when 0 it waits in IDLE for init_start.
- BLANK_COLOR, 6'h0F, colour index returned on reads while the store is not valid (IDLE or LOAD).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- init_start  input  1  single-cycle pulse; starts a ROM-to-store copy (accepted in IDLE or READY).
- init_busy  output  1  high while in LOAD.
- init_done  output  1  single-cycle pulse on the last LOAD cycle.
- rom_addr  output  5  address to the palette ROM.
- rom_data  input  8  ROM data, valid in the same cycle as rom_addr; only bits [5:0] are used.
- rd_en  input  1  render read request.
- rd_addr  input  5  render read address.
- rd_data  output  6  colour index, registered.
- rd_valid  output  1  rd_data valid; one cycle after the accepted rd_en.
- wr_en  input  1  host write request; held high until wr_ack.
- wr_addr  input  5  host write address.
- wr_data  input  8  host write data; only bits [5:0] are stored.
- wr_ack  output  1  single-cycle pulse when the write is committed.

Behaviour:
Address canonicalisation:
- canon(a) = {1'b0, a[3:0]} when a[4]==1 and a[1:0]==2'b00; otherwise canon(a) = a.
- Every store access uses canon(), so 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C.

Storage:
- 32x6 register array.
- Reset clears every entry to 6'h00; the valid flag clears to 0.

Reset values:
- rom_addr=0, rd_data=0, rd_valid=0, wr_ack=0, init_busy=0, init_done=0.
- State = IDLE.
- rst_n asserted mid-LOAD aborts the copy; the store is cleared.

FSM:
- IDLE: reads return BLANK_COLOR; writes are not acked.
  - Goes to LOAD on init_start, or on the first cycle after reset when AUTO_INIT=1.
- LOAD: a 5-bit counter drives rom_addr from 0 to 31, one address per cycle, 32 cycles total.
  - Each cycle: store[rom_addr] <= rom_data[5:0].
  - The writes for 0x10/0x14/0x18/0x1C are skipped, so the base entries keep the values from 0x00/0x04/0x08/0x0C.
  - At count 31: init_done pulses, the valid flag is set, and the FSM goes to READY.
  - Reads return BLANK_COLOR with rd_valid; writes are stalled (no ack).
  - init_start during LOAD is ignored.
- READY: normal service. init_start goes to LOAD and clears the valid flag; a pending wr_en is stalled until the copy finishes.

Arbitration in READY (one store access per cycle):
- Render read has strict priority.
- If rd_en and wr_en occur together, the read is served, and the write is held with no ack that cycle.
- The write commits on the first cycle with rd_en=0, with wr_ack high in that same cycle. Write latency is therefore 1 cycle minimum, unbounded while rd_en stays high.
- After wr_ack, the host must drop wr_en or present a new request. A still-high wr_en in the following cycle is a new write.

Read timing:
- rd_data = store[canon(rd_addr)] registered; rd_valid = rd_en delayed by 1 cycle.
- A read in the cycle after a write to the same canonical address returns the new value. There is no bypass within the same cycle; the read wins anyway.
- When rd_en=0, rd_data holds its last value.

Optional Feature:
Macro: PALETTE_GRAYSCALE_EN
- Defined: adds input port `gray` (1 bit). When gray=1 at read accept, the registered rd_data is store[canon(rd_addr)] & 6'h30, the NES PPUMASK greyscale behaviour.
- Not defined: no port is added and rd_data is unmasked.

Test Plan:
1. Reset released with AUTO_INIT=1 and the standard ROM image (0x00=0x15, 0x02=0x27, 0x1D=0x02) -> init_busy high for exactly 32 cycles, rom_addr steps 0..31, init_done pulses on cycle 32.
2. After load, rd_en with rd_addr=0x02 -> next cycle rd_valid=1, rd_data=0x27. rd_addr=0x1D -> 0x02. rd_addr=0x10 -> 0x15 (mirror of 0x00).
3. Write wr_addr=0x14, wr_data=0x2A with rd_en=0 -> wr_ack in the same cycle. A later read of 0x04 returns 0x2A, and a read of 0x14 also returns 0x2A.
4. wr_en (addr 0x05, data 0x11) with rd_en held high for 3 cycles -> no wr_ack for 3 cycles, reads served correctly. wr_ack on the 4th cycle; a read of 0x05 then returns 0x11.
5. Read during LOAD (rd_addr=0x02) -> rd_data=0x0F. rst_n pulsed low at LOAD count 10 -> all outputs return to 0, the store is cleared, and a fresh 32-cycle LOAD follows.
6. With PALETTE_GRAYSCALE_EN defined: gray=1 and read of 0x02 (0x27) -> rd_data=0x20. gray=0 -> 0x27.

Source files
------------

// File: rtl/palette_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// palette_ram_ctrl_if
// Bus between the palette controller and its two clients:
//   render read port : rd_en, rd_addr  -> rd_data (6b colour), rd_valid
//   host write port  : wr_en, wr_addr, wr_data (8b, low 6 stored) -> wr_ack
// The master modport belongs to the render/host side.
// The slave modport belongs to palette_ram_ctrl.
// ---------------------------------------------------------------------------
interface palette_ram_ctrl_if;
   logic       rd_en;
   logic [4:0] rd_addr;
   logic [5:0] rd_data;
   logic       rd_valid;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ack;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_data, rd_valid, wr_ack
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_data, rd_valid, wr_ack
   );
endinterface

// File: rtl/palette_ram_ctrl.sv
// ---------------------------------------------------------------------------
// palette_ram_ctrl
// NES PPU palette controller.
// After reset, or when init_start is pulsed, it copies a 32-entry
// combinational palette ROM into a writable 32x6 store. It then serves
// render reads (with priority) and host writes from that store. Both ports
// apply the $3F10/$3F14/$3F18/$3F1C mirroring.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   init_start  : pulse, starts a ROM copy (accepted in IDLE or READY)
//   init_busy   : high while copying
//   init_done   : pulse on the final copy cycle
//   rom_addr    : ROM address; rom_data is valid in the same cycle
//   rom_data    : ROM data, low 6 bits used
//   gray        : (PALETTE_GRAYSCALE_EN only) mask read colours to & 6'h30
//   bus         : palette_ram_ctrl_if.slave (render read / host write)
//
// Optional feature macro: PALETTE_GRAYSCALE_EN
// ---------------------------------------------------------------------------
module palette_ram_ctrl #(
   parameter bit         AUTO_INIT   = 1'b1,
   parameter logic [5:0] BLANK_COLOR = 6'h0F
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               init_start,
   output logic               init_busy,
   output logic               init_done,
   output logic [4:0]         rom_addr,
   input  logic [7:0]         rom_data,
`ifdef PALETTE_GRAYSCALE_EN
   input  logic               gray,
`endif
   palette_ram_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

   state_t     state;
   state_t     next_state;
   logic [4:0] load_count;
   logic       count_last;
   logic       auto_pending;
   logic       store_valid;
   logic       load_write;
   logic       host_write;
   logic [5:0] read_mask;
   logic [5:0] store [32];
   logic       unused_high_bits;

   // The sprite backdrop entries 0x10/0x14/0x18/0x1C share storage with
   // 0x00/0x04/0x08/0x0C.
   function automatic logic is_alias(input logic [4:0] a);
      return a[4] && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [4:0] canon(input logic [4:0] a);
      return is_alias(a) ? {1'b0, a[3:0]} : a;
   endfunction

   assign count_last       = (load_count == 5'd31);
   assign unused_high_bits = ^{rom_data[7:6], bus.wr_data[7:6]};

   // The greyscale mask keeps only the luminance bits of the colour index.
   // Without the feature, the mask lets every bit through.
`ifdef PALETTE_GRAYSCALE_EN
   assign read_mask = gray ? 6'h30 : 6'h3F;
`else
   assign read_mask = 6'h3F;
`endif

   // State register. Reset always returns to IDLE, which also aborts a copy
   // that is in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // auto_pending is high only for the first cycle after reset. That lets
   // AUTO_INIT start a copy exactly once, with no external pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         auto_pending <= 1'b1;
      end else begin
         auto_pending <= 1'b0;
      end
   end

   // Next-state logic. A copy always runs all 32 addresses. init_start is
   // ignored while a copy runs.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (init_start || (AUTO_INIT && auto_pending)) next_state = LOAD;
         LOAD:    if (count_last) next_state = READY;
         READY:   if (init_start) next_state = LOAD;
         default: next_state = IDLE;
      endcase
   end

   // Output decode. A host write commits only in READY, only when no render
   // read wants the store, and only when no new copy is starting this cycle.
   // A write that is blocked stays pending on wr_en until it can commit.
   always_comb begin
      init_busy  = 1'b0;
      init_done  = 1'b0;
      rom_addr   = 5'd0;
      load_write = 1'b0;
      host_write = 1'b0;
      bus.wr_ack = 1'b0;
      case (state)
         LOAD: begin
            init_busy  = 1'b1;
            init_done  = count_last;
            rom_addr   = load_count;
            load_write = !is_alias(load_count);
         end
         READY: begin
            host_write = bus.wr_en && !bus.rd_en && !init_start;
            bus.wr_ack = host_write;
         end
         default: ;
      endcase
   end

   // The copy counter starts at zero in every LOAD and wraps naturally after 31.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_count <= 5'd0;
      end else if (state == LOAD) begin
         load_count <= load_count + 5'd1;
      end else begin
         load_count <= 5'd0;
      end
   end

   // The store is valid from the end of a complete copy until the next copy starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_valid <= 1'b0;
      end else if (state == LOAD && count_last) begin
         store_valid <= 1'b1;
      end else if (state == READY && init_start) begin
         store_valid <= 1'b0;
      end
   end

   // Palette store. The copy skips the mirror addresses, so the base entries
   // keep the ROM values for 0x00/0x04/0x08/0x0C. Copy writes and host writes
   // can never happen in the same cycle, because they belong to different states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            store[i] <= 6'h00;
         end
      end else if (load_write) begin
         store[load_count] <= rom_data[5:0];
      end else if (host_write) begin
         store[canon(bus.wr_addr)] <= bus.wr_data[5:0];
      end
   end

   // Registered read port. Every accepted read produces rd_valid in the next
   // cycle. Until the store is valid, the read returns the blank colour.
   // When no read is accepted, rd_data keeps its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_data  <= 6'h00;
         bus.rd_valid <= 1'b0;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            bus.rd_data <= store_valid ? (store[canon(bus.rd_addr)] & read_mask)
                                       : BLANK_COLOR;
         end
      end
   end

endmodule

// File: tb/tb_palette_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_palette_ram_ctrl
// Directed bench for palette_ram_ctrl, using the default AUTO_INIT=1 and
// BLANK_COLOR=6'h0F. The ROM image is a small table of hand-chosen values.
// Some mirror entries hold different data from their base entries, so that
// a copy which fails to skip the mirrors is visible.
// ---------------------------------------------------------------------------
module tb_palette_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       init_start;
   logic       init_busy;
   logic       init_done;
   logic [4:0] rom_addr;
   logic [7:0] rom_data;
`ifdef PALETTE_GRAYSCALE_EN
   logic       gray;
`endif
   logic [7:0] rom_image [32];
   int         compared   = 0;
   int         mismatched = 0;

   typedef struct {
      logic       rd_en;
      logic [4:0] addr;
      logic       exp_valid;
      logic [5:0] exp_data;
   } read_vec_t;

   read_vec_t vecs [12];

   palette_ram_ctrl_if bus ();

   palette_ram_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_start (init_start),
      .init_busy  (init_busy),
      .init_done  (init_done),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
`ifdef PALETTE_GRAYSCALE_EN
      .gray       (gray),
`endif
      .bus        (bus)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // The combinational ROM: data follows the address in the same cycle.
   assign rom_data = rom_image[rom_addr];

   // Watchdog that ends a hung run with a failure line.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drives one cycle of inputs on the falling edge, then waits 1 unit.
   // After it returns, combinational outputs reflect these inputs and
   // registered outputs reflect the previous cycle.
   task automatic applyStimulus(input logic start, input logic rd_en,
                                input logic [4:0] rd_addr, input logic wr_en,
                                input logic [4:0] wr_addr, input logic [7:0] wr_data);
      @(negedge clk);
      init_start  = start;
      bus.rd_en   = rd_en;
      bus.rd_addr = rd_addr;
      bus.wr_en   = wr_en;
      bus.wr_addr = wr_addr;
      bus.wr_data = wr_data;
      #1;
   endtask

   task automatic checkRead(input string tag, input read_vec_t v);
      checkOutput({tag, " rd_valid"}, 8'(bus.rd_valid), 8'(v.exp_valid));
      checkOutput({tag, " rd_data"}, 8'(bus.rd_data), 8'(v.exp_data));
   endtask

   // Follows a full copy. It checks the address sequence, the init_done
   // timing, that writes are stalled, and that the copy lasts exactly 32
   // cycles. It returns in the first cycle after the copy.
   task automatic runLoad(input string tag);
      int n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         init_start = 1'b0;
         #1;
         if (init_busy) begin
            checkOutput({tag, " rom_addr"}, 8'(rom_addr), 8'(n));
            checkOutput({tag, " wr_ack in load"}, 8'(bus.wr_ack), 8'd0);
            if (n == 30) checkOutput({tag, " init_done early"}, 8'(init_done), 8'd0);
            if (n == 31) checkOutput({tag, " init_done"}, 8'(init_done), 8'd1);
            n++;
         end else if (n > 0) begin
            break;
         end
      end
      checkOutput({tag, " busy cycles"}, 8'(n), 8'd32);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " rom_addr"}, 8'(rom_addr), 8'd0);
      checkOutput({tag, " rd_data"}, 8'(bus.rd_data), 8'd0);
      checkOutput({tag, " rd_valid"}, 8'(bus.rd_valid), 8'd0);
      checkOutput({tag, " wr_ack"}, 8'(bus.wr_ack), 8'd0);
      checkOutput({tag, " init_busy"}, 8'(init_busy), 8'd0);
      checkOutput({tag, " init_done"}, 8'(init_done), 8'd0);
   endtask

   initial begin
      read_vec_t v;
      bit        found;

      for (int i = 0; i < 32; i++) rom_image[i] = 8'h00;
      rom_image[5'h00] = 8'h15;
      rom_image[5'h02] = 8'h27;
      rom_image[5'h03] = 8'hC5;
      rom_image[5'h04] = 8'h21;
      rom_image[5'h05] = 8'h06;
      rom_image[5'h08] = 8'h09;
      rom_image[5'h0C] = 8'h1A;
      rom_image[5'h10] = 8'h3F;
      rom_image[5'h14] = 8'h33;
      rom_image[5'h18] = 8'h3C;
      rom_image[5'h1C] = 8'h2E;
      rom_image[5'h1D] = 8'h02;
      rom_image[5'h1F] = 8'h30;

      // Each expected result is the one seen in the cycle after its request.
      vecs[0]  = '{1'b1, 5'h02, 1'b1, 6'h27};
      vecs[1]  = '{1'b1, 5'h1D, 1'b1, 6'h02};
      vecs[2]  = '{1'b1, 5'h10, 1'b1, 6'h15};
      vecs[3]  = '{1'b1, 5'h00, 1'b1, 6'h15};
      vecs[4]  = '{1'b1, 5'h03, 1'b1, 6'h05};
      vecs[5]  = '{1'b0, 5'h1F, 1'b0, 6'h05};
      vecs[6]  = '{1'b1, 5'h14, 1'b1, 6'h21};
      vecs[7]  = '{1'b1, 5'h04, 1'b1, 6'h21};
      vecs[8]  = '{1'b1, 5'h1C, 1'b1, 6'h1A};
      vecs[9]  = '{1'b1, 5'h18, 1'b1, 6'h09};
      vecs[10] = '{1'b1, 5'h05, 1'b1, 6'h06};
      vecs[11] = '{1'b1, 5'h1F, 1'b1, 6'h30};

`ifdef PALETTE_GRAYSCALE_EN
      gray = 1'b0;
`endif
      rst_n = 1'b0;
      applyStimulus(0, 0, 5'h00, 0, 5'h00, 8'h00);
      applyStimulus(0, 0, 5'h00, 0, 5'h00, 8'h00);
      checkResetOutputs("reset");

      // Releasing reset starts the automatic copy.
      @(negedge clk);
      rst_n = 1'b1;
      runLoad("autoload");

      // Table of back-to-back reads.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, vecs[i].rd_en, vecs[i].addr, 0, 5'h00, 8'h00);
         if (i > 0) checkRead($sformatf("vec%0d", i - 1), vecs[i - 1]);
      end
      applyStimulus(0, 0, 5'h00, 0, 5'h00, 8'h00);
      checkRead("vec11", vecs[11]);

      // A write to a mirror address is acked in the same cycle.
      // Both aliases then read back the new value.
      applyStimulus(0, 0, 5'h00, 1, 5'h14, 8'hEA);
      checkOutput("mirror write ack", 8'(bus.wr_ack), 8'd1);
      applyStimulus(0, 1, 5'h04, 0, 5'h00, 8'h00);
      checkOutput("ack drops", 8'(bus.wr_ack), 8'd0);
      applyStimulus(0, 1, 5'h14, 0, 5'h00, 8'h00);
      v = '{1'b1, 5'h04, 1'b1, 6'h2A};
      checkRead("read 0x04 after write", v);
      applyStimulus(0, 0, 5'h00, 0, 5'h00, 8'h00);
      checkRead("read 0x14 after write", v);

      // A write held off by three cycles of reads, then committed.
      applyStimulus(0, 1, 5'h02, 1, 5'h05, 8'h11);
      checkOutput("stall ack c1", 8'(bus.wr_ack), 8'd0);
      applyStimulus(0, 1, 5'h1D, 1, 5'h05, 8'h11);
      checkOutput("stall ack c2", 8'(bus.wr_ack), 8'd0);
      checkOutput("stall read c1", 8'(bus.rd_data), 8'h27);
      applyStimulus(0, 1, 5'h00, 1, 5'h05, 8'h11);
      checkOutput("stall ack c3", 8'(bus.wr_ack), 8'd0);
      checkOutput("stall read c2", 8'(bus.rd_data), 8'h02);
      applyStimulus(0, 0, 5'h00, 1, 5'h05, 8'h11);
      checkOutput("stall ack c4", 8'(bus.wr_ack), 8'd1);
      checkOutput("stall read c3", 8'(bus.rd_data), 8'h15);
      applyStimulus(0, 1, 5'h05, 0, 5'h00, 8'h00);
      checkOutput("no ack after drop", 8'(bus.wr_ack), 8'd0);
      applyStimulus(0, 0, 5'h00, 0, 5'h00, 8'h00);
      checkOutput("read 0x05 after stall", 8'(bus.rd_data), 8'h11);

`ifdef PALETTE_GRAYSCALE_EN
      gray = 1'b1;
      applyStimulus(0, 1, 5'h02, 0, 5'h00, 8'h00);
      gray = 1'b0;
      applyStimulus(0, 1, 5'h02, 0, 5'h00, 8'h00);
      checkOutput("gray read", 8'(bus.rd_data), 8'h20);
      applyStimulus(0, 0, 5'h00, 0, 5'h00, 8'h00);
      checkOutput("colour read", 8'(bus.rd_data), 8'h27);
`endif

      // A re-init with a write pending. The write waits for the copy to
      // finish, and then lands on top of the freshly loaded image.
      applyStimulus(1, 0, 5'h00, 1, 5'h05, 8'h33);
      checkOutput("ack blocked by init", 8'(bus.wr_ack), 8'd0);
      runLoad("reinit");
      checkOutput("pending write ack", 8'(bus.wr_ack), 8'd1);
      applyStimulus(0, 1, 5'h04, 0, 5'h00, 8'h00);
      checkOutput("pending ack drops", 8'(bus.wr_ack), 8'd0);
      applyStimulus(0, 1, 5'h05, 0, 5'h00, 8'h00);
      checkOutput("reinit restores 0x04", 8'(bus.rd_data), 8'h21);
      applyStimulus(0, 0, 5'h00, 0, 5'h00, 8'h00);
      checkOutput("pending write landed", 8'(bus.rd_data), 8'h33);

      // A read during a copy returns the blank colour. Reset at count 10
      // aborts the copy, and a fresh automatic copy follows.
      applyStimulus(1, 0, 5'h00, 0, 5'h00, 8'h00);
      applyStimulus(0, 1, 5'h02, 0, 5'h00, 8'h00);
      checkOutput("load started", 8'(init_busy), 8'd1);
      applyStimulus(0, 0, 5'h02, 0, 5'h00, 8'h00);
      checkOutput("load read valid", 8'(bus.rd_valid), 8'd1);
      checkOutput("load read blank", 8'(bus.rd_data), 8'h0F);
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (init_busy && rom_addr == 5'd10) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      checkOutput("reached count 10", 8'(found), 8'd1);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("mid-load reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      runLoad("reload");
      applyStimulus(0, 1, 5'h05, 0, 5'h00, 8'h00);
      applyStimulus(0, 1, 5'h14, 0, 5'h00, 8'h00);
      checkOutput("reload 0x05", 8'(bus.rd_data), 8'h06);
      applyStimulus(0, 0, 5'h00, 0, 5'h00, 8'h00);
      checkOutput("reload 0x14", 8'(bus.rd_data), 8'h21);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
